// File: rtl/mc_controller_ws.sv
// Multicycle MIPS controller: main-decode FSM, ALU decode, memory wait states,
// illegal-instruction flag and retired-instruction counter.
module mc_controller_ws #(
    parameter int unsigned ALUC_W   = 3,
    parameter bit          MEM_WAIT = 1'b1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pcen,
    output logic              memwrite,
    output logic              irwrite,
    output logic              regwrite,
    output logic              iord,
    output logic              memtoreg,
    output logic              regdst,
    output logic              alusrca,
    output logic [2:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic [ALUC_W-1:0] alucontrol,
    output logic [1:0]        lb,
    output logic              illegal,
    output logic [3:0]        state_o,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StIExec  = 4'd9,
        StIWb    = 4'd10,
        StJump   = 4'd11
    } state_t;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpSlti = 6'b001010;
    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpLb   = 6'b100000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpLbu  = 6'b100100;
    localparam logic [5:0] OpSw   = 6'b101011;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_retired;
    logic              w_rdy;
    logic              w_pcwrite;
    logic              w_branch;
    logic              w_bne;
    logic              w_retire;
    logic [2:0]        w_aluc;
    logic [2:0]        w_aluc_funct;
    logic              w_funct_ok;
    logic [1:0]        w_lb_mode;

    assign w_rdy = mem_ready | ~MEM_WAIT;

    always_comb begin
        w_funct_ok   = 1'b1;
        w_aluc_funct = AluAdd;
        case (funct)
            6'b100000: w_aluc_funct = AluAdd;
            6'b100010: w_aluc_funct = AluSub;
            6'b100100: w_aluc_funct = AluAnd;
            6'b100101: w_aluc_funct = AluOr;
            6'b101010: w_aluc_funct = AluSlt;
            default:   w_funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        w_lb_mode = 2'b00;
        if (op == OpLb) begin
            w_lb_mode = 2'b01;
        end else if (op == OpLbu) begin
            w_lb_mode = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign retired = r_retired;

    always_comb begin
        w_next    = StFetch;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        w_bne     = 1'b0;
        w_retire  = 1'b0;
        w_aluc    = AluAnd;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 3'b000;
        pcsrc     = 2'b00;
        lb        = 2'b00;
        illegal   = 1'b0;
        case (r_state)
            StFetch: begin
                alusrcb   = 3'b001;
                w_aluc    = AluAdd;
                irwrite   = w_rdy;
                w_pcwrite = w_rdy;
                w_next    = w_rdy ? StDecode : StFetch;
            end
            StDecode: begin
                alusrcb = 3'b011;
                w_aluc  = AluAdd;
                case (op)
                    OpLw, OpSw, OpLb, OpLbu:         w_next = StMemAdr;
                    OpBeq, OpBne:                    w_next = StBranch;
                    OpAddi, OpSlti, OpAndi, OpOri:   w_next = StIExec;
                    OpJ:                             w_next = StJump;
                    OpR: begin
                        if (w_funct_ok) begin
                            w_next = StExec;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default:                         illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
                w_aluc  = AluAdd;
                w_next  = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord   = 1'b1;
                lb     = w_lb_mode;
                w_next = w_rdy ? StMemWb : StMemRd;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                lb       = w_lb_mode;
                w_retire = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                w_retire = w_rdy;
                w_next   = w_rdy ? StFetch : StMemWr;
            end
            StExec: begin
                alusrca = 1'b1;
                w_aluc  = w_aluc_funct;
                w_next  = StAluWb;
            end
            StAluWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                w_retire = 1'b1;
            end
            StIExec: begin
                alusrca = 1'b1;
                w_next  = StIWb;
                case (op)
                    OpSlti: begin alusrcb = 3'b010; w_aluc = AluSlt; end
                    OpAndi: begin alusrcb = 3'b100; w_aluc = AluAnd; end
                    OpOri:  begin alusrcb = 3'b100; w_aluc = AluOr;  end
                    default: begin alusrcb = 3'b010; w_aluc = AluAdd; end
                endcase
            end
            StIWb: begin
                regwrite = 1'b1;
                w_retire = 1'b1;
            end
            StBranch: begin
                alusrca  = 1'b1;
                w_aluc   = AluSub;
                pcsrc    = 2'b01;
                w_branch = (op == OpBeq);
                w_bne    = (op == OpBne);
                w_retire = 1'b1;
            end
            StJump: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_retire  = 1'b1;
            end
            default: w_next = StFetch;
        endcase

        pcen       = w_pcwrite | (w_branch & zero) | (w_bne & ~zero);
        alucontrol = ALUC_W'(w_aluc);
        state_o    = r_state;

        // Everything observable is held at zero for as long as reset is asserted.
        if (!reset) begin
            pcen       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            iord       = 1'b0;
            memtoreg   = 1'b0;
            regdst     = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 3'b000;
            pcsrc      = 2'b00;
            lb         = 2'b00;
            illegal    = 1'b0;
            alucontrol = '0;
            state_o    = 4'd0;
            w_retire   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller_ws.sv
// Randomised scoreboard bench for mc_controller_ws: per-instruction expected cycle
// records are queued by the stimulus and compared by a negedge monitor.
module tb_mc_controller_ws;

    localparam int unsigned ALUC_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [2:0] alusrcb;
        logic [1:0] pcsrc;
        logic [3:0] aluc;
        logic [1:0] lb;
        logic       illegal;
        logic [3:0] ret;
    } rec_t;

    typedef enum int {CMem, CR, CBr, CImm, CJ, CIll} cls_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic              zero;
    logic              mem_ready;
    logic              pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [2:0]        alusrcb;
    logic [1:0]        pcsrc;
    logic [ALUC_W-1:0] alucontrol;
    logic [1:0]        lb;
    logic              illegal;
    logic [3:0]        state_o;
    logic [CNT_W-1:0]  retired;

    int   checks = 0;
    int   errors = 0;
    int   mret   = 0;
    int   ncyc   = 0;
    rec_t q[$];

    mc_controller_ws #(
        .ALUC_W   (ALUC_W),
        .MEM_WAIT (1'b1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .lb         (lb),
        .illegal    (illegal),
        .state_o    (state_o),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        rec_t e;
        rec_t a;
        ncyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {state_o, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                 alusrcb, pcsrc, alucontrol, lb, illegal, retired};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle%0d state%0d got %h want %h", ncyc, e.st, a, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011, 6'b101011, 6'b100000, 6'b100100: return CMem;
            6'b000100, 6'b000101:                       return CBr;
            6'b001000, 6'b001010, 6'b001100, 6'b001101: return CImm;
            6'b000010:                                  return CJ;
            6'b000000: begin
                if (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                    f == 6'b100101 || f == 6'b101010) return CR;
                return CIll;
            end
            default: return CIll;
        endcase
    endfunction

    function automatic logic [3:0] rfunct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic rec_t blank(input int st);
        rec_t e;
        e     = '0;
        e.st  = 4'(st);
        e.ret = 4'(mret);
        return e;
    endfunction

    task automatic step(input rec_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd();
        zero      = 1'($urandom);
        mem_ready = 1'($urandom);
    endtask

    task automatic retire();
        mret = (mret + 1) % (1 << CNT_W);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        mret  = 0;
        for (int i = 0; i < n; i++) begin
            rnd();
            step(blank(0));
        end
        reset = 1'b1;
    endtask

    // zb: forced zero flag in BRANCH (-1 = random); abort: MEMWR wait index at which
    // reset is dropped mid-cycle (-1 = never).
    task automatic issue(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                         input int zb, input int abort, output bit aborted);
        rec_t       e;
        cls_t       c;
        logic [1:0] lbv;
        aborted = 1'b0;
        c       = classify(o, f);
        lbv     = (o == 6'b100000) ? 2'b01 : (o == 6'b100100) ? 2'b10 : 2'b00;
        op      = o;
        funct   = f;
        for (int i = 0; i <= fw; i++) begin
            zero      = 1'($urandom);
            mem_ready = (i == fw);
            e = blank(0);
            e.alusrcb = 3'b001;
            e.aluc    = 4'b0010;
            e.irwrite = (i == fw);
            e.pcen    = (i == fw);
            step(e);
        end
        rnd();
        e = blank(1);
        e.alusrcb = 3'b011;
        e.aluc    = 4'b0010;
        e.illegal = (c == CIll);
        step(e);
        case (c)
            CMem: begin
                rnd();
                e = blank(2);
                e.alusrca = 1'b1;
                e.alusrcb = 3'b010;
                e.aluc    = 4'b0010;
                step(e);
                if (o == 6'b101011) begin
                    for (int i = 0; i <= mw; i++) begin
                        zero      = 1'($urandom);
                        mem_ready = (i == mw);
                        e = blank(5);
                        e.iord     = 1'b1;
                        e.memwrite = 1'b1;
                        if (i == abort) begin
                            q.push_back(e);
                            @(negedge clk);
                            #2;
                            reset = 1'b0;
                            #1;
                            check("abort_memwrite", int'(memwrite), 0);
                            check("abort_state", int'(state_o), 0);
                            check("abort_retired", int'(retired), 0);
                            mret    = 0;
                            aborted = 1'b1;
                            @(posedge clk);
                            #1;
                            return;
                        end
                        step(e);
                    end
                    retire();
                end else begin
                    for (int i = 0; i <= mw; i++) begin
                        zero      = 1'($urandom);
                        mem_ready = (i == mw);
                        e = blank(3);
                        e.iord = 1'b1;
                        e.lb   = lbv;
                        step(e);
                    end
                    rnd();
                    e = blank(4);
                    e.memtoreg = 1'b1;
                    e.regwrite = 1'b1;
                    e.lb       = lbv;
                    step(e);
                    retire();
                end
            end
            CR: begin
                rnd();
                e = blank(6);
                e.alusrca = 1'b1;
                e.aluc    = rfunct_alu(f);
                step(e);
                rnd();
                e = blank(7);
                e.regdst   = 1'b1;
                e.regwrite = 1'b1;
                step(e);
                retire();
            end
            CBr: begin
                rnd();
                if (zb >= 0) zero = 1'(zb);
                e = blank(8);
                e.alusrca = 1'b1;
                e.aluc    = 4'b0110;
                e.pcsrc   = 2'b01;
                e.pcen    = (o == 6'b000100) ? zero : ~zero;
                step(e);
                retire();
            end
            CImm: begin
                rnd();
                e = blank(9);
                e.alusrca = 1'b1;
                case (o)
                    6'b001010: begin e.alusrcb = 3'b010; e.aluc = 4'b0111; end
                    6'b001100: begin e.alusrcb = 3'b100; e.aluc = 4'b0000; end
                    6'b001101: begin e.alusrcb = 3'b100; e.aluc = 4'b0001; end
                    default:   begin e.alusrcb = 3'b010; e.aluc = 4'b0010; end
                endcase
                step(e);
                rnd();
                e = blank(10);
                e.regwrite = 1'b1;
                step(e);
                retire();
            end
            CJ: begin
                rnd();
                e = blank(11);
                e.pcsrc = 2'b10;
                e.pcen  = 1'b1;
                step(e);
                retire();
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops [13];
        logic [5:0] fns [5];
        logic [5:0] o;
        logic [5:0] f;
        bit         ab;
        ops = '{6'b100011, 6'b101011, 6'b100000, 6'b100100, 6'b000000, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset     = 1'b0;
        op        = '0;
        funct     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);
        issue(6'b000000, 6'b100000, 0, 0, -1, -1, ab);   // R add
        issue(6'b100011, 6'b000000, 2, 3, -1, -1, ab);   // lw with waits
        issue(6'b000101, 6'b000000, 0, 0, 0, -1, ab);    // bne, zero=0
        issue(6'b000100, 6'b000000, 0, 0, 0, -1, ab);    // beq, zero=0
        issue(6'b001100, 6'b000000, 0, 0, -1, -1, ab);   // andi
        issue(6'b100100, 6'b000000, 0, 1, -1, -1, ab);   // lbu
        issue(6'b111111, 6'b000000, 0, 0, -1, -1, ab);   // illegal op
        issue(6'b000000, 6'b000000, 0, 0, -1, -1, ab);   // illegal funct
        for (int i = 0; i < 16; i++) begin
            issue(6'b000000, fns[i % 5], 0, 0, -1, -1, ab);
        end
        issue(6'b101011, 6'b000000, 1, 3, -1, 1, ab);    // sw aborted by reset
        do_reset(2);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                o = 6'($urandom);
            end else begin
                o = ops[$urandom_range(0, 12)];
            end
            if ($urandom_range(0, 7) == 0) begin
                f = 6'($urandom);
            end else begin
                f = fns[$urandom_range(0, 4)];
            end
            issue(o, f, $urandom_range(0, 2), $urandom_range(0, 2), -1, -1, ab);
        end
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
